// File: rtl/ula_pkg.sv
`default_nettype none
// ula_pkg: shared types and constants for the ULA clone interrupt path.
// Revision 1.0
package ula_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PENDING = 3'd1,
    S_GRACE   = 3'd2,
    S_DRIVE   = 3'd3,
    S_RELEASE = 3'd4
  } ack_state_t;

  localparam logic [7:0] FLOAT_BUS     = 8'hFF;
  localparam int         GRACE_DEFAULT = 8;
  localparam logic [8:0] LAT_MAX       = 9'd511;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [8:0] sat_inc_lat(input logic [8:0] v);
    return (v == LAT_MAX) ? v : v + 9'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync2.sv
`default_nettype none
// sync2: 1-bit two-flop synchronizer, both stages reset to 1 (inactive strobe level).
// Revision 1.0
module sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q1,
  output logic q2
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q1 <= 1'b1;
      q2 <= 1'b1;
    end else begin
      q1 <= d;
      q2 <= q1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/intack_responder.sv
`default_nettype none
// intack_responder: detects the Z80 interrupt-acknowledge cycle, drives the vector or floating bus,
// and reports acknowledge latency, spurious acknowledges and missed frame interrupts. Revision 1.0
module intack_responder
  import ula_pkg::*;
#(
  parameter int GRACE = GRACE_DEFAULT
) (
  input  logic       clk14,
  input  logic       reset,
  input  logic       int_n,
  input  logic       m1_n,
  input  logic       iorq_n,
  input  logic       vector_en,
  input  logic [7:0] vector,
  output logic [7:0] d_out,
  output logic       d_oe,
  output logic       int_pending,
  output logic       int_acked,
  output logic       spurious,
  output logic [7:0] missed_cnt,
  output logic [8:0] latency
);

  localparam int             GW         = (GRACE > 1) ? $clog2(GRACE) : 1;
  localparam logic [GW-1:0]  GRACE_LOAD = GW'(GRACE - 1);

  logic unused_m1_q1;
  logic m1_s;
  logic iorq_q1;
  logic iorq_s;
  logic ack_s;
  logic bus_free;
  logic [7:0] drive_byte;

  ack_state_t    state;
  logic [8:0]    lat_cnt;
  logic [GW-1:0] grace_cnt;
  logic          served;

  sync2 u_sync_m1 (
    .clk   (clk14),
    .reset (reset),
    .d     (m1_n),
    .q1    (unused_m1_q1),
    .q2    (m1_s)
  );

  sync2 u_sync_iorq (
    .clk   (clk14),
    .reset (reset),
    .d     (iorq_n),
    .q1    (iorq_q1),
    .q2    (iorq_s)
  );

  assign ack_s       = ~m1_s & ~iorq_s;
  assign bus_free    = m1_s & iorq_s;
  assign drive_byte  = vector_en ? vector : FLOAT_BUS;
  assign int_pending = (state == S_PENDING) || (state == S_GRACE);

  // served blocks a still-low int_n from re-arming the same frame after its acknowledge.
  always_ff @(posedge clk14 or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      lat_cnt    <= 9'd0;
      grace_cnt  <= '0;
      served     <= 1'b0;
      d_out      <= FLOAT_BUS;
      d_oe       <= 1'b0;
      int_acked  <= 1'b0;
      spurious   <= 1'b0;
      missed_cnt <= 8'd0;
      latency    <= 9'd0;
    end else begin
      int_acked <= 1'b0;
      if (int_n) begin
        served <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (!int_n && !served) begin
            state   <= S_PENDING;
            lat_cnt <= 9'd0;
          end else if (ack_s) begin
            state    <= S_DRIVE;
            spurious <= 1'b1;
            d_oe     <= 1'b1;
            d_out    <= drive_byte;
          end
        end

        S_PENDING: begin
          lat_cnt <= sat_inc_lat(lat_cnt);
          if (ack_s) begin
            state     <= S_DRIVE;
            int_acked <= 1'b1;
            latency   <= lat_cnt;
            served    <= 1'b1;
            d_oe      <= 1'b1;
            d_out     <= drive_byte;
          end else if (int_n) begin
            state     <= S_GRACE;
            grace_cnt <= GRACE_LOAD;
          end
        end

        S_GRACE: begin
          lat_cnt <= sat_inc_lat(lat_cnt);
          if (ack_s) begin
            state     <= S_DRIVE;
            int_acked <= 1'b1;
            latency   <= lat_cnt;
            served    <= 1'b1;
            d_oe      <= 1'b1;
            d_out     <= drive_byte;
          end else if (!int_n) begin
            state <= S_PENDING;
          end else if (grace_cnt == '0) begin
            state      <= S_IDLE;
            missed_cnt <= sat_inc8(missed_cnt);
          end else begin
            grace_cnt <= grace_cnt - 1'b1;
          end
        end

        // First synchronizer stage lets the bus turn around one edge sooner.
        S_DRIVE: begin
          if (iorq_q1) begin
            state <= S_RELEASE;
            d_oe  <= 1'b0;
          end
        end

        S_RELEASE: begin
          if (bus_free) begin
            state <= S_IDLE;
          end
        end

        default: begin
          state <= S_IDLE;
          d_oe  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_intack_responder.sv
`default_nettype none
// tb_intack_responder: directed-vector bench for intack_responder with immediate-assertion checks.
// Revision 1.0
module tb_intack_responder;

  logic       clk14;
  logic       reset;
  logic       int_n;
  logic       m1_n;
  logic       iorq_n;
  logic       vector_en;
  logic [7:0] vector;
  logic [7:0] d_out;
  logic       d_oe;
  logic       int_pending;
  logic       int_acked;
  logic       spurious;
  logic [7:0] missed_cnt;
  logic [8:0] latency;

  int vectors;
  int miscompares;

  intack_responder #(.GRACE(8)) dut (
    .clk14       (clk14),
    .reset       (reset),
    .int_n       (int_n),
    .m1_n        (m1_n),
    .iorq_n      (iorq_n),
    .vector_en   (vector_en),
    .vector      (vector),
    .d_out       (d_out),
    .d_oe        (d_oe),
    .int_pending (int_pending),
    .int_acked   (int_acked),
    .spurious    (spurious),
    .missed_cnt  (missed_cnt),
    .latency     (latency)
  );

  initial clk14 = 1'b0;
  always #5 clk14 = ~clk14;

  task automatic tick();
    @(posedge clk14);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic frame_no_ack();
    int_n = 1'b0;
    tick();
    int_n = 1'b1;
    repeat (9) tick();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    int_n       = 1'b1;
    m1_n        = 1'b1;
    iorq_n      = 1'b1;
    vector_en   = 1'b0;
    vector      = 8'h00;
    repeat (3) tick();

    chk("rst_d_oe", 16'(d_oe), 16'h0);
    chk("rst_d_out", 16'(d_out), 16'h00FF);
    chk("rst_pending", 16'(int_pending), 16'h0);
    chk("rst_acked", 16'(int_acked), 16'h0);
    chk("rst_spurious", 16'(spurious), 16'h0);
    chk("rst_missed", 16'(missed_cnt), 16'h0);
    chk("rst_latency", 16'(latency), 16'h0);
    reset = 1'b0;
    repeat (2) tick();

    // Frame with acknowledge strobes falling 20 cycles after int_n.
    int_n = 1'b0;
    tick();
    chk("t1_pending", 16'(int_pending), 16'h1);
    repeat (19) tick();
    m1_n   = 1'b0;
    iorq_n = 1'b0;
    repeat (2) tick();
    chk("t1_oe_early", 16'(d_oe), 16'h0);
    tick();
    chk("t1_acked", 16'(int_acked), 16'h1);
    chk("t1_oe", 16'(d_oe), 16'h1);
    chk("t1_dout", 16'(d_out), 16'h00FF);
    chk("t1_latency", 16'(latency), 16'd21);
    chk("t1_pend_clr", 16'(int_pending), 16'h0);
    tick();
    chk("t1_ack_pulse", 16'(int_acked), 16'h0);
    chk("t1_oe_hold", 16'(d_oe), 16'h1);
    m1_n   = 1'b1;
    iorq_n = 1'b1;
    tick();
    chk("t1_oe_r1", 16'(d_oe), 16'h1);
    tick();
    chk("t1_oe_r2", 16'(d_oe), 16'h0);
    repeat (30) tick();
    int_n = 1'b1;
    repeat (12) tick();
    chk("t1_missed", 16'(missed_cnt), 16'h0);
    chk("t1_idle", 16'(int_pending), 16'h0);

    // Vector mode: byte latched on DRIVE entry.
    vector_en = 1'b1;
    vector    = 8'hA5;
    int_n     = 1'b0;
    tick();
    m1_n   = 1'b0;
    iorq_n = 1'b0;
    repeat (3) tick();
    chk("t2_acked", 16'(int_acked), 16'h1);
    chk("t2_dout", 16'(d_out), 16'h00A5);
    chk("t2_latency", 16'(latency), 16'd2);
    vector = 8'h00;
    tick();
    chk("t2_dout_hold", 16'(d_out), 16'h00A5);
    chk("t2_oe", 16'(d_oe), 16'h1);
    m1_n   = 1'b1;
    iorq_n = 1'b1;
    repeat (2) tick();
    chk("t2_oe_off", 16'(d_oe), 16'h0);
    int_n     = 1'b1;
    vector_en = 1'b0;
    repeat (4) tick();

    // Unacknowledged frame expires exactly GRACE cycles after int_n rises.
    int_n = 1'b0;
    tick();
    int_n = 1'b1;
    tick();
    chk("t3_grace_pend", 16'(int_pending), 16'h1);
    repeat (7) tick();
    chk("t3_missed_early", 16'(missed_cnt), 16'h0);
    chk("t3_pend_early", 16'(int_pending), 16'h1);
    tick();
    chk("t3_missed", 16'(missed_cnt), 16'h1);
    chk("t3_pend_off", 16'(int_pending), 16'h0);

    // Acknowledge inside the grace window.
    int_n = 1'b0;
    tick();
    int_n = 1'b1;
    repeat (3) tick();
    m1_n   = 1'b0;
    iorq_n = 1'b0;
    repeat (3) tick();
    chk("t4_acked", 16'(int_acked), 16'h1);
    chk("t4_latency", 16'(latency), 16'd5);
    chk("t4_missed", 16'(missed_cnt), 16'h1);
    chk("t4_spurious", 16'(spurious), 16'h0);
    m1_n   = 1'b1;
    iorq_n = 1'b1;
    repeat (4) tick();

    // Acknowledge after the grace window closed: spurious, still driven.
    int_n = 1'b0;
    tick();
    int_n = 1'b1;
    repeat (9) tick();
    chk("t5_missed", 16'(missed_cnt), 16'h2);
    tick();
    m1_n   = 1'b0;
    iorq_n = 1'b0;
    repeat (2) tick();
    chk("t5_oe_early", 16'(d_oe), 16'h0);
    tick();
    chk("t5_oe", 16'(d_oe), 16'h1);
    chk("t5_spurious", 16'(spurious), 16'h1);
    chk("t5_no_ack", 16'(int_acked), 16'h0);
    chk("t5_dout", 16'(d_out), 16'h00FF);
    m1_n   = 1'b1;
    iorq_n = 1'b1;
    repeat (4) tick();

    // Opcode fetch and I/O cycles are not acknowledges.
    m1_n = 1'b0;
    repeat (5) tick();
    chk("t6_m1_oe", 16'(d_oe), 16'h0);
    chk("t6_m1_pend", 16'(int_pending), 16'h0);
    m1_n   = 1'b1;
    iorq_n = 1'b0;
    repeat (5) tick();
    chk("t6_io_oe", 16'(d_oe), 16'h0);
    chk("t6_io_ack", 16'(int_acked), 16'h0);
    iorq_n = 1'b1;
    repeat (3) tick();

    // int_n rise coincides with ack_s: acknowledge wins, no grace/miss.
    int_n = 1'b0;
    tick();
    m1_n   = 1'b0;
    iorq_n = 1'b0;
    repeat (2) tick();
    int_n = 1'b1;
    tick();
    chk("t7_acked", 16'(int_acked), 16'h1);
    chk("t7_latency", 16'(latency), 16'd2);
    chk("t7_pend", 16'(int_pending), 16'h0);
    m1_n   = 1'b1;
    iorq_n = 1'b1;
    repeat (14) tick();
    chk("t7_missed", 16'(missed_cnt), 16'h2);

    // Missed counter saturation.
    for (int i = 0; i < 253; i++) frame_no_ack();
    chk("t8_missed_255", 16'(missed_cnt), 16'h00FF);
    for (int i = 0; i < 47; i++) frame_no_ack();
    chk("t8_missed_sat", 16'(missed_cnt), 16'h00FF);

    // Latency saturation, then reset while the bus is driven.
    int_n = 1'b0;
    tick();
    repeat (520) tick();
    m1_n   = 1'b0;
    iorq_n = 1'b0;
    repeat (3) tick();
    chk("t9_latency_sat", 16'(latency), 16'd511);
    chk("t9_oe", 16'(d_oe), 16'h1);
    chk("t9_acked", 16'(int_acked), 16'h1);
    reset = 1'b1;
    #1;
    chk("t9_rst_oe", 16'(d_oe), 16'h0);
    chk("t9_rst_dout", 16'(d_out), 16'h00FF);
    chk("t9_rst_acked", 16'(int_acked), 16'h0);
    chk("t9_rst_spurious", 16'(spurious), 16'h0);
    chk("t9_rst_missed", 16'(missed_cnt), 16'h0);
    chk("t9_rst_latency", 16'(latency), 16'h0);
    chk("t9_rst_pend", 16'(int_pending), 16'h0);
    m1_n   = 1'b1;
    iorq_n = 1'b1;
    int_n  = 1'b1;
    tick();
    reset = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
